// File: rtl/counter_host.sv
// rtl/counter_host.sv - initiator-side controller that preloads and polls an 8-bit loadable counter
//
// Purpose:
//   Accepts a (start, target) command, loads the counter with start,
//   enables its output, and polls every cycle until the count equals
//   target, the command is aborted, or TIMEOUT poll cycles elapse.
//   It then pulses done and reports the elapsed poll count and status.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_start/cmd_target are the payload
//   cmd_abort            abandons the command while polling
//   cnt_load_e/_val      counter preload strobe and value
//   cnt_out_e            counter output enable
//   cnt_out_data         counter value (0 while cnt_out_e is low)
//   busy                 command in LOAD or POLL
//   done                 one-cycle completion pulse
//   timed_out, aborted   completion qualifiers, valid until the next accept
//   elapsed              poll cycles consumed by the last command

module counter_host #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 300,
  parameter int CYC_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_abort,
  output logic             cnt_load_e,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_out_e,
  input  logic [WIDTH-1:0] cnt_out_data,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             aborted,
  output logic [CYC_W-1:0] elapsed
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_POLL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CYC_W-1:0] LAST_POLL = CYC_W'(TIMEOUT - 1);

  state_t           state_q;
  logic             cmd_ready_q;
  logic             cnt_load_e_q;
  logic [WIDTH-1:0] cnt_load_val_q;  // doubles as the captured start value
  logic             cnt_out_e_q;
  logic             busy_q;
  logic             done_q;
  logic             timed_out_q;
  logic             aborted_q;
  logic [CYC_W-1:0] elapsed_q;
  logic [CYC_W-1:0] elapsed_d;
  logic [WIDTH-1:0] target_q;
  logic             match_d;
  logic             last_d;

  always_comb begin
    elapsed_d = elapsed_q + CYC_W'(1);
    match_d   = (cnt_out_data == target_q);
    last_d    = (elapsed_q == LAST_POLL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cmd_ready_q    <= 1'b1;
      cnt_load_e_q   <= 1'b0;
      cnt_load_val_q <= '0;
      cnt_out_e_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timed_out_q    <= 1'b0;
      aborted_q      <= 1'b0;
      elapsed_q      <= '0;
      target_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // cmd_ready_q is always 1 here, so cmd_valid alone is the accept.
          if (cmd_valid) begin
            state_q        <= S_LOAD;
            cmd_ready_q    <= 1'b0;
            cnt_load_e_q   <= 1'b1;
            cnt_load_val_q <= cmd_start;
            target_q       <= cmd_target;
            busy_q         <= 1'b1;
            elapsed_q      <= '0;
            timed_out_q    <= 1'b0;
            aborted_q      <= 1'b0;
          end
        end
        S_LOAD: begin
          // The counter takes the preload on this edge, so the first
          // POLL cycle observes count == start.
          state_q      <= S_POLL;
          cnt_load_e_q <= 1'b0;
          cnt_out_e_q  <= 1'b1;
        end
        S_POLL: begin
          // Abort beats match, match beats timeout.
          if (cmd_abort || match_d || last_d) begin
            state_q     <= S_DONE;
            cnt_out_e_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            aborted_q   <= cmd_abort;
            timed_out_q <= !cmd_abort && !match_d;
          end else begin
            elapsed_q <= elapsed_d;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign cnt_load_e   = cnt_load_e_q;
  assign cnt_load_val = cnt_load_val_q;
  assign cnt_out_e    = cnt_out_e_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timed_out    = timed_out_q;
  assign aborted      = aborted_q;
  assign elapsed      = elapsed_q;

endmodule
